// File: rtl/pll_lock_sequencer_if.sv
// Loop-control bundle between the PFD/charge-pump analog block, the CSRs and the lock sequencer.
// The sequencer owns the slave side; the control/status block (or a bench) owns the master side.
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 15
);
  logic             run;
  logic             pfd_pol;
  logic             pfd_enable;
  logic             ref_clk;
  logic             cp_oe;
  logic             cp_fast;
  logic             locked;
  logic             ref_present;
  logic [1:0]       state;
  logic [CNT_W-1:0] err_count;

  modport master (
    output run, pfd_pol, pfd_enable, ref_clk,
    input  cp_oe, cp_fast, locked, ref_present, state, err_count
  );

  modport slave (
    input  run, pfd_pol, pfd_enable, ref_clk,
    output cp_oe, cp_fast, locked, ref_present, state, err_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Windowed PFD/reference monitor that walks the VCXO loop through DISABLED/NO_REF/ACQUIRE/LOCKED.
// Decisions are taken on the last cycle of each window and are visible on the following cycle.
module pll_lock_sequencer #(
  parameter int WIN_CYCLES    = 16384,
  parameter int CNT_W         = 15,
  parameter int LOCK_THRESH   = 64,
  parameter int UNLOCK_THRESH = 256,
  parameter int LOCK_WINDOWS  = 8,
  parameter int REF_MIN       = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pll_lock_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_NO_REF   = 2'b01,
    ST_ACQUIRE  = 2'b10,
    ST_LOCKED   = 2'b11
  } state_e;

  localparam int               WIN_W   = $clog2(WIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             pol_meta_q, pol_unused_q;
  logic [1:0]       en_sync_q;
  logic [2:0]       ref_sync_q;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] err_acc_q, err_acc_d;
  logic [CNT_W-1:0] ref_acc_q, ref_acc_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             ref_present_q, ref_present_d;
  logic             cp_oe_q, cp_oe_d;
  logic             cp_fast_q, cp_fast_d;
  logic             locked_q, locked_d;

  logic             pump_act, ref_edge, win_end;
  logic [CNT_W-1:0] err_sum, ref_sum;
  logic             ref_ok, err_sat, good_win, bad_lock;
  logic [7:0]       good_inc;

  // pfd_enable is active-low: a low synced sample is one cycle of pump activity.
  assign pump_act = ~en_sync_q[1];
  assign ref_edge = ref_sync_q[1] & ~ref_sync_q[2];
  assign win_end  = (win_cnt_q == WIN_W'(WIN_CYCLES - 1));

  // Window totals including the current cycle's samples, saturating at all-ones.
  assign err_sum  = (pump_act && (err_acc_q != CNT_MAX)) ? err_acc_q + CNT_W'(1) : err_acc_q;
  assign ref_sum  = (ref_edge && (ref_acc_q != CNT_MAX)) ? ref_acc_q + CNT_W'(1) : ref_acc_q;

  assign ref_ok   = (int'(ref_sum) >= REF_MIN);
  assign err_sat  = (err_sum == CNT_MAX);
  assign good_win = !err_sat && (int'(err_sum) <= LOCK_THRESH);
  assign bad_lock = err_sat || (int'(err_sum) > UNLOCK_THRESH);
  assign good_inc = good_cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q + WIN_W'(1);
    err_acc_d     = err_sum;
    ref_acc_d     = ref_sum;
    good_cnt_d    = good_cnt_q;
    err_count_d   = err_count_q;
    ref_present_d = ref_present_q;

    if (!bus.run) begin
      state_d    = ST_DISABLED;
      win_cnt_d  = '0;
      err_acc_d  = '0;
      ref_acc_d  = '0;
      good_cnt_d = '0;
    end else if (win_end) begin
      win_cnt_d     = '0;
      err_acc_d     = '0;
      ref_acc_d     = '0;
      err_count_d   = err_sum;
      ref_present_d = ref_ok;
      // A missing reference overrides every lock decision for this window.
      if (!ref_ok) begin
        state_d    = ST_NO_REF;
        good_cnt_d = '0;
      end else begin
        unique case (state_q)
          ST_DISABLED, ST_NO_REF: begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = '0;
          end
          ST_ACQUIRE: begin
            if (!good_win) begin
              good_cnt_d = '0;
            end else if (good_inc >= 8'(LOCK_WINDOWS)) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_inc;
            end
          end
          ST_LOCKED: begin
            if (bad_lock) begin
              state_d    = ST_ACQUIRE;
              good_cnt_d = '0;
            end
          end
        endcase
      end
    end

    cp_oe_d   = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
    cp_fast_d = (state_d == ST_ACQUIRE);
    locked_d  = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_meta_q    <= 1'b0;
      pol_unused_q  <= 1'b0;
      en_sync_q     <= '0;
      ref_sync_q    <= '0;
      state_q       <= ST_DISABLED;
      win_cnt_q     <= '0;
      err_acc_q     <= '0;
      ref_acc_q     <= '0;
      good_cnt_q    <= '0;
      err_count_q   <= '0;
      ref_present_q <= 1'b0;
      cp_oe_q       <= 1'b0;
      cp_fast_q     <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      pol_meta_q    <= bus.pfd_pol;
      pol_unused_q  <= pol_meta_q;
      en_sync_q     <= {en_sync_q[0], bus.pfd_enable};
      ref_sync_q    <= {ref_sync_q[1:0], bus.ref_clk};
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      err_acc_q     <= err_acc_d;
      ref_acc_q     <= ref_acc_d;
      good_cnt_q    <= good_cnt_d;
      err_count_q   <= err_count_d;
      ref_present_q <= ref_present_d;
      cp_oe_q       <= cp_oe_d;
      cp_fast_q     <= cp_fast_d;
      locked_q      <= locked_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.err_count   = err_count_q;
  assign bus.ref_present = ref_present_q;
  assign bus.cp_oe       = cp_oe_q;
  assign bus.cp_fast     = cp_fast_q;
  assign bus.locked      = locked_q;

endmodule
